// File: rtl/plic_cfg_sequencer_if.sv
// AXI4 write-only channel bundle (AW/W/B) used by the PLIC configuration sequencer.
// 32-bit address and data, 2-bit ID.
interface plic_cfg_sequencer_if;
  logic [1:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/plic_cfg_sequencer.sv
// Programs PLIC source priorities, context-0 enables and threshold with a
// sequence of single-beat AXI4 writes, one outstanding at a time.
module plic_cfg_sequencer #(
  parameter int unsigned NUM_SRC   = 31,
  parameter logic [31:0] PLIC_BASE = 32'h0
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [3*NUM_SRC-1:0]   prio_i,
  input  logic [31:0]            enable_i,
  input  logic [2:0]             threshold_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   err_o,
  plic_cfg_sequencer_if.master   m_axi
);

  localparam int unsigned IDX_W  = $clog2(NUM_SRC + 2);
  localparam int unsigned PRIO_W = 3 * NUM_SRC;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SRC + 1);
  localparam logic [IDX_W-1:0] EN_IDX   = IDX_W'(NUM_SRC);

  typedef enum logic [1:0] {IDLE, ISSUE, BRESP, DONE} state_e;

  // Address of write number idx: priorities, then enable word, then threshold.
  function automatic logic [31:0] wr_addr(input logic [IDX_W-1:0] idx);
    if (32'(idx) < NUM_SRC)  return PLIC_BASE + (32'(idx) << 2) + 32'd4;
    else if (idx == EN_IDX)  return PLIC_BASE + 32'h0000_2000;
    else                     return PLIC_BASE + 32'h0020_0000;
  endfunction

  function automatic logic [31:0] wr_data(input logic [IDX_W-1:0] idx,
                                          input logic [PRIO_W-1:0] prio,
                                          input logic [31:0] en,
                                          input logic [2:0] thr);
    if (32'(idx) < NUM_SRC)  return {29'b0, prio[3*int'(idx) +: 3]};
    else if (idx == EN_IDX)  return en & 32'hFFFF_FFFE;  // source 0 is reserved
    else                     return {29'b0, thr};
  endfunction

  state_e             state_q;
  logic [IDX_W-1:0]   idx_q;
  logic [IDX_W-1:0]   idx_d;
  logic [PRIO_W-1:0]  prio_q;
  logic [31:0]        en_q;
  logic [2:0]         thr_q;
  logic [31:0]        awaddr_q;
  logic [31:0]        wdata_q;
  logic               awvalid_q;
  logic               wvalid_q;
  logic               bready_q;
  logic               busy_q;
  logic               done_q;
  logic               err_q;
  logic               aw_done;
  logic               w_done;
  logic               unused_bid;

  assign idx_d   = idx_q + IDX_W'(1);
  assign aw_done = !awvalid_q || m_axi.awready;
  assign w_done  = !wvalid_q  || m_axi.wready;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      prio_q    <= '0;
      en_q      <= '0;
      thr_q     <= '0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            prio_q    <= prio_i;
            en_q      <= enable_i;
            thr_q     <= threshold_i;
            err_q     <= 1'b0;
            idx_q     <= '0;
            awaddr_q  <= wr_addr('0);
            wdata_q   <= wr_data('0, prio_i, enable_i, threshold_i);
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= ISSUE;
          end
        end
        ISSUE: begin
          // AW and W retire independently; move on once both have been accepted.
          if (m_axi.awready) awvalid_q <= 1'b0;
          if (m_axi.wready)  wvalid_q  <= 1'b0;
          if (aw_done && w_done) begin
            bready_q <= 1'b1;
            state_q  <= BRESP;
          end
        end
        BRESP: begin
          if (m_axi.bvalid) begin
            bready_q <= 1'b0;
            if (m_axi.bresp != 2'b00 || idx_q == LAST_IDX) begin
              err_q   <= err_q | (m_axi.bresp != 2'b00);
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              idx_q     <= idx_d;
              awaddr_q  <= wr_addr(idx_d);
              wdata_q   <= wr_data(idx_d, prio_q, en_q, thr_q);
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state_q   <= ISSUE;
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign unused_bid = ^m_axi.bid;

  assign m_axi.awid    = 2'b00;
  assign m_axi.awaddr  = awaddr_q;
  assign m_axi.awlen   = 8'd0;
  assign m_axi.awsize  = 3'b010;
  assign m_axi.awburst = 2'b01;
  assign m_axi.awvalid = awvalid_q;
  assign m_axi.wdata   = wdata_q;
  assign m_axi.wstrb   = 4'hF;
  assign m_axi.wlast   = 1'b1;
  assign m_axi.wvalid  = wvalid_q;
  assign m_axi.bready  = bready_q;

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign err_o  = err_q;

endmodule

// File: tb/tb_plic_cfg_sequencer.sv
// Directed bench for plic_cfg_sequencer with NUM_SRC=2 and a small
// configurable AXI write slave that logs every accepted address and data beat.
module tb_plic_cfg_sequencer;
  localparam int unsigned NSRC = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        start = 1'b0;
  logic [5:0]  prio  = '0;
  logic [31:0] en    = '0;
  logic [2:0]  thr   = '0;
  logic        busy, done, err;

  plic_cfg_sequencer_if m_axi();

  plic_cfg_sequencer #(.NUM_SRC(NSRC), .PLIC_BASE(32'h0)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .prio_i(prio),
    .enable_i(en), .threshold_i(thr), .busy_o(busy), .done_o(done),
    .err_o(err), .m_axi(m_axi)
  );

  always #5 clk = ~clk;

  // Slave: ready after a programmable number of waiting cycles, B once both beats arrived.
  int unsigned  aw_dly = 0, w_dly = 0;
  int           err_at = -1, run_base = 0;
  int unsigned  aw_cnt, w_cnt;
  logic         got_aw, got_w;
  int           b_cnt = 0, done_cnt = 0, viol_bready = 0, viol_outst = 0;
  logic [31:0]  aw_log[$];
  logic [31:0]  w_log[$];

  always_comb begin
    m_axi.awready = m_axi.awvalid && (aw_cnt >= aw_dly);
    m_axi.wready  = m_axi.wvalid  && (w_cnt  >= w_dly);
  end
  assign m_axi.bvalid = got_aw && got_w;
  assign m_axi.bresp  = ((b_cnt - run_base) == err_at) ? 2'b10 : 2'b00;
  assign m_axi.bid    = 2'b00;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_cnt <= 0; w_cnt <= 0; got_aw <= 1'b0; got_w <= 1'b0;
    end else begin
      if (m_axi.awvalid && m_axi.awready) begin
        aw_cnt <= 0; got_aw <= 1'b1; aw_log.push_back(m_axi.awaddr);
        if (got_aw) viol_outst <= viol_outst + 1;
      end else if (m_axi.awvalid) aw_cnt <= aw_cnt + 1;
      if (m_axi.wvalid && m_axi.wready) begin
        w_cnt <= 0; got_w <= 1'b1; w_log.push_back(m_axi.wdata);
        if (got_w) viol_outst <= viol_outst + 1;
      end else if (m_axi.wvalid) w_cnt <= w_cnt + 1;
      if (m_axi.bvalid && m_axi.bready) begin
        got_aw <= 1'b0; got_w <= 1'b0; b_cnt <= b_cnt + 1;
      end
      if (m_axi.bready && (m_axi.awvalid || m_axi.wvalid)) viol_bready <= viol_bready + 1;
      if (done) done_cnt <= done_cnt + 1;
    end
  end

  int n_chk = 0, n_pass = 0;
  int aw_base = 0, w_base = 0, done_base = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Leaves the bench at the negedge of the first ISSUE cycle.
  task automatic pulse_start;
    @(negedge clk);
    run_base = b_cnt; aw_base = aw_log.size(); w_base = w_log.size(); done_base = done_cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (done) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    check(tag, 32'(seen), 32'd1);
  endtask

  task automatic check_writes(input string tag, input logic [31:0] d0, input logic [31:0] d1,
                              input logic [31:0] d2, input logic [31:0] d3);
    logic [31:0] ea[4];
    logic [31:0] ed[4];
    ea = '{32'h4, 32'h8, 32'h2000, 32'h20_0000};
    ed = '{d0, d1, d2, d3};
    check($sformatf("%s_aw_count", tag), 32'(aw_log.size() - aw_base), 32'd4);
    check($sformatf("%s_w_count", tag), 32'(w_log.size() - w_base), 32'd4);
    if (aw_log.size() - aw_base == 4 && w_log.size() - w_base == 4) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("%s_addr%0d", tag, i), aw_log[aw_base + i], ea[i]);
        check($sformatf("%s_data%0d", tag, i), w_log[w_base + i], ed[i]);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_outputs", 32'({busy, done, err, m_axi.awvalid, m_axi.wvalid, m_axi.bready}), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_outputs", 32'({busy, done, err, m_axi.awvalid, m_axi.wvalid, m_axi.bready}), 32'd0);

    // Basic sequence, slave always ready, all OKAY
    prio = 6'b011_101; en = 32'hFFFF_FFFF; thr = 3'd1;
    pulse_start();
    check("basic_busy", 32'(busy), 32'd1);
    wait_done("basic_done");
    check("basic_busy_in_done", 32'(busy), 32'd0);
    check("basic_err", 32'(err), 32'd0);
    check_writes("basic", 32'd5, 32'd3, 32'hFFFF_FFFE, 32'd1);
    repeat (3) @(negedge clk);
    check("basic_done_pulses", 32'(done_cnt - done_base), 32'd1);
    check("basic_done_low", 32'(done), 32'd0);

    // AW accepted after 3 wait cycles, W immediately
    aw_dly = 3;
    pulse_start();
    check("dly_c1_valids", 32'({m_axi.awvalid, m_axi.wvalid, m_axi.bready}), 32'b110);
    check("dly_c1_fixed", 32'({m_axi.awid, m_axi.awlen, m_axi.awsize, m_axi.awburst, m_axi.wstrb, m_axi.wlast}),
          32'({2'b00, 8'd0, 3'b010, 2'b01, 4'hF, 1'b1}));
    check("dly_c1_wdata", m_axi.wdata, 32'd5);
    @(negedge clk);
    check("dly_c2_valids", 32'({m_axi.awvalid, m_axi.wvalid, m_axi.bready}), 32'b100);
    check("dly_c2_addr", m_axi.awaddr, 32'h4);
    @(negedge clk);
    check("dly_c3_addr", 32'({m_axi.awvalid, m_axi.bready}), 32'b10);
    check("dly_c3_addr_stable", m_axi.awaddr, 32'h4);
    @(negedge clk);
    check("dly_c4_valids", 32'({m_axi.awvalid, m_axi.wvalid, m_axi.bready}), 32'b100);
    @(negedge clk);
    check("dly_c5_bresp_phase", 32'({m_axi.awvalid, m_axi.wvalid, m_axi.bready, busy}), 32'b0011);
    wait_done("dly_done");
    check_writes("dly", 32'd5, 32'd3, 32'hFFFF_FFFE, 32'd1);
    aw_dly = 0;

    // SLVERR on the second write aborts the sequence
    err_at = 1;
    pulse_start();
    wait_done("slverr_done");
    check("slverr_err", 32'(err), 32'd1);
    check("slverr_aw_count", 32'(aw_log.size() - aw_base), 32'd2);
    repeat (5) @(negedge clk);
    check("slverr_no_more_aw", 32'(aw_log.size() - aw_base), 32'd2);
    check("slverr_sticky", 32'({err, busy}), 32'b10);
    err_at = -1;
    pulse_start();
    check("restart_err_cleared", 32'(err), 32'd0);
    wait_done("restart_done");
    check("restart_err", 32'(err), 32'd0);
    check_writes("restart", 32'd5, 32'd3, 32'hFFFF_FFFE, 32'd1);

    // Inputs and start changed while busy must not disturb the run
    prio = 6'b110_010; en = 32'h0000_00F1; thr = 3'd3;
    pulse_start();
    prio = 6'b111_111; en = 32'h0; thr = 3'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("latch_done");
    check_writes("latch", 32'd2, 32'd6, 32'h0000_00F0, 32'd3);
    repeat (6) @(negedge clk);
    check("latch_single_run", 32'(aw_log.size() - aw_base), 32'd4);
    check("latch_done_pulses", 32'(done_cnt - done_base), 32'd1);
    check("latch_idle", 32'(busy), 32'd0);

    // Reset while AW is pending drops valids at once and does not resume
    aw_dly = 5;
    pulse_start();
    @(negedge clk);
    check("rst_pre_awvalid", 32'(m_axi.awvalid), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_async_valids", 32'({m_axi.awvalid, m_axi.wvalid, m_axi.bready, busy}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    aw_base = aw_log.size();
    repeat (10) @(negedge clk);
    check("rst_no_resume", 32'({busy, done, err, m_axi.awvalid, m_axi.wvalid}), 32'd0);
    check("rst_no_aw", 32'(aw_log.size() - aw_base), 32'd0);
    aw_dly = 0;

    // Fresh run after reset uses the current inputs
    pulse_start();
    wait_done("post_rst_done");
    check_writes("post_rst", 32'd7, 32'd7, 32'h0, 32'd7);

    check("bready_only_after_handshakes", 32'(viol_bready), 32'd0);
    check("single_outstanding", 32'(viol_outst), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
